// File: rtl/retro_input_pkg.sv
// Shared types and constants for the retro input conditioner: debounce FSM
// states, channel ordering and which channels get hold-to-repeat.
package retro_input_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } deb_state_t;

  localparam int CH_COIN10 = 0;
  localparam int CH_COIN25 = 1;
  localparam int CH_NEXT   = 2;
  localparam int CH_SELECT = 3;

  localparam logic [3:0] REPEAT_EN_DEFAULT = 4'b0100;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, debounce FSM with stability counter and an
// optional hold-to-repeat counter. event_o is decoded from flops only.
module debounce_channel
  import retro_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic event_o,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q;
  logic                   press_evt;
  logic                   rep_evt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == PRESSED) || (state_d == RELEASE_CHECK);
    end
  end

  // The counter stops at CNT_LAST because the FSM leaves the check state there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      RELEASED: begin
        if (synced) begin
          state_d = PRESS_CHECK;
          cnt_d   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!synced) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_d = RELEASE_CHECK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (synced) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int REP_W = $clog2(REPEAT_DELAY + 1);
      localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

      logic [REP_W-1:0] rep_q, rep_d;

      // Reloading to DELAY-PERIOD after each repeat spaces later pulses by PERIOD.
      always_comb begin
        rep_d   = '0;
        rep_evt = 1'b0;
        if (state_q == PRESSED && synced) begin
          if (rep_q == REP_LAST) begin
            rep_evt = 1'b1;
            rep_d   = REP_RELOAD;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_d;
        end
      end
    end else begin : g_no_repeat
      assign rep_evt = 1'b0;
    end
  endgenerate

  assign event_o = press_evt | rep_evt;
  assign level_o = level_q;

endmodule

// File: rtl/retro_input_conditioner.sv
// Four debounced input channels feeding registered event pulses; coin events
// landing together are serialised, coin_25 first.
module retro_input_conditioner
  import retro_input_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         REPEAT_DELAY    = 50_000_000,
  parameter int         REPEAT_PERIOD   = 20_000_000,
  parameter int         SYNC_STAGES     = 2,
  parameter logic [3:0] REPEAT_EN       = REPEAT_EN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_10_raw,
  input  logic       coin_25_raw,
  input  logic       next_item_raw,
  input  logic       select_raw,
  output logic       coin_10,
  output logic       coin_25,
  output logic       next_item,
  output logic       select,
  output logic [3:0] level
);

  logic [3:0] raw_vec;
  logic [3:0] evt;
  logic [3:0] lvl_vec;

  assign raw_vec = {select_raw, next_item_raw, coin_25_raw, coin_10_raw};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .SYNC_STAGES    (SYNC_STAGES),
        .REPEAT_EN      (REPEAT_EN[gi])
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw_vec[gi]),
        .event_o(evt[gi]),
        .level_o(lvl_vec[gi])
      );
    end
  endgenerate

  logic coin_10_q, coin_10_d;
  logic coin_25_q, coin_25_d;
  logic next_q, next_d;
  logic select_q, select_d;
  logic pend_q, pend_d;
  logic c10_want;

  // A coin_10 colliding with coin_25 waits one cycle in pend_q.
  always_comb begin
    c10_want  = evt[CH_COIN10] | pend_q;
    coin_25_d = evt[CH_COIN25];
    coin_10_d = c10_want & ~evt[CH_COIN25];
    pend_d    = c10_want & evt[CH_COIN25];
    next_d    = evt[CH_NEXT];
    select_d  = evt[CH_SELECT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coin_10_q <= 1'b0;
      coin_25_q <= 1'b0;
      next_q    <= 1'b0;
      select_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      coin_10_q <= coin_10_d;
      coin_25_q <= coin_25_d;
      next_q    <= next_d;
      select_q  <= select_d;
      pend_q    <= pend_d;
    end
  end

  assign coin_10   = coin_10_q;
  assign coin_25   = coin_25_q;
  assign next_item = next_q;
  assign select    = select_q;
  assign level     = lvl_vec;

endmodule

// File: doc/retro_input_conditioner.md
# retro_input_conditioner

Conditions the four raw, asynchronous push-button and coin-mech inputs (coin_10, coin_25, next_item, select) before they reach retro_vending. Each input is synchronised, debounced and reduced to a single-cycle event pulse. next_item gets hold-to-repeat. Simultaneous coin events are serialised so the vending FSM never sees two coin pulses in one cycle. Sits between the board pins and retro_vending in the system clock domain.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles an input must be stable before a level change is accepted (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles next_item must be held before the first repeat pulse.
- REPEAT_PERIOD, 20_000_000: cycles between subsequent repeat pulses.
- SYNC_STAGES, 2: flip-flops in each input synchroniser; minimum 2.
- clk  in  1  system clock (same `clk` that drives retro_vending).
- reset  in  1  synchronous, active-high reset; one clock; driven by startup_reset.
- coin_10_raw, coin_25_raw, next_item_raw, select_raw  in  1 each  asynchronous pins, active high.
- coin_10, coin_25, next_item, select  out  1 each  registered single-cycle event pulses.
- level  out  4  debounced levels, {select, next_item, coin_25, coin_10}.

## Operation
- Each channel is a SYNC_STAGES-deep synchroniser followed by a debounce FSM and a counter.
- FSM states and transitions:
  - RELEASED: on synced=1, go to PRESS_CHECK with count cleared.
  - PRESS_CHECK: count increments while synced=1. On synced=0, go to RELEASED. When count reaches DEBOUNCE_CYCLES-1 with synced=1, go to PRESSED and emit the event.
  - PRESSED: on synced=0, go to RELEASE_CHECK with count cleared.
  - RELEASE_CHECK: count increments while synced=0. On synced=1, return to PRESSED with no event. When count reaches DEBOUNCE_CYCLES-1, go to RELEASED.
- level bit is 1 in PRESSED and RELEASE_CHECK, 0 otherwise.
- Repeat applies to next_item only:
  - Repeat counter runs while in PRESSED.
  - First repeat pulse after REPEAT_DELAY cycles in PRESSED, then one every REPEAT_PERIOD cycles.
  - Counter clears whenever the channel leaves PRESSED.
  - Coins and select never repeat: exactly one event per debounced press.
- Coin arbitration:
  - If coin_10 and coin_25 events occur in the same cycle, coin_25 is emitted that cycle.
  - The coin_10 event is held in a one-bit pending register and emitted the next cycle.
  - A new coin_10 event arriving while pending is set merges into it. Coin events are ≥ DEBOUNCE_CYCLES apart per channel, so this cannot occur when DEBOUNCE_CYCLES>1.
- Counter widths are $clog2(max value + 1). Counters saturate and never wrap.

## Timing
- Reset values:
  - All synchroniser flops: 0.
  - All FSMs: RELEASED.
  - All counters: 0.
  - Pending bit: 0.
  - All pulse outputs: 0.
  - level: 4'b0000.
- Press latency: raw first sampled high at edge 0 and held high, so the synced value is 1 after edge SYNC_STAGES. The event pulse is high for exactly the one cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES.
- level rises on the same cycle as the pulse.
- level falls SYNC_STAGES+DEBOUNCE_CYCLES cycles after raw is first sampled low.
- Bounce: any return to the old level before the count completes restarts the check. No event is produced until a full stable window has elapsed.
- Reset mid-operation: any in-flight check or pending coin_10 is discarded and no pulse is emitted during or after the reset cycle.
  - A button still held when reset deasserts yields one event SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first post-reset sample.
- Outputs are pure flop outputs. No combinational path exists from raw inputs.

## Structure
- Package retro_input_pkg holds:
  - Enum deb_state_t {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK}.
  - Channel index constants CH_COIN10=0, CH_COIN25=1, CH_NEXT=2, CH_SELECT=3.
  - Default REPEAT_EN mask 4'b0100.
- Sub-module debounce_channel: synchroniser, FSM, debounce counter, optional repeat counter. Parameter REPEAT_EN enables repeat per instance.
- The top instantiates four channels and adds the coin arbiter and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, SYNC_STAGES=2. t=0 is the first edge sampling raw high.
- Clean press: coin_10_raw high for 12 cycles, then low. Expect coin_10 pulse in the cycle after edge 6 only, level[0] high from that cycle, and level[0] low 6 cycles after raw first sampled low.
- Bounce: select_raw toggles every cycle for 6 cycles, then stays high. Expect exactly one select pulse, 6 cycles after the stable-high start. No pulse during the toggling.
- Simultaneous coins: coin_10_raw and coin_25_raw driven identically high. Expect coin_25 after edge 6 and coin_10 after edge 7, never both high in one cycle.
- Repeat and hold:
  - next_item_raw held 60 cycles: pulses after edges 6, 26, 34, 42, 50, 58.
  - select_raw held 60 cycles: one pulse only.
- Release glitch: after a coin_25 press is accepted, coin_25_raw drops low for 2 cycles, then returns high. Expect no second pulse and level[1] staying 1 throughout.
- Reset mid-press: reset asserted at edge 4 for 1 cycle while next_item_raw is held. Expect no pulse around the reset, then one pulse 6 cycles after the first post-reset sample, and all outputs 0 during reset.
